// File: rtl/radix6_pkg.sv
// ============================================================================
// radix6_pkg
// Shared frame geometry, triplet lane-to-slot maps and read FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package radix6_pkg;

    localparam int FRAME_N   = 6;
    localparam int TRIPLET_N = 3;

    typedef logic [2:0] slot_t;

    // Lane k of the even/odd triplet reads frame slot MAP[k]
    localparam slot_t EVEN_MAP [TRIPLET_N] = '{3'd0, 3'd2, 3'd4};
    localparam slot_t ODD_MAP  [TRIPLET_N] = '{3'd1, 3'd3, 3'd5};

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_EVEN = 2'd1,
        RD_ODD  = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/radix6_input_commutator_if.sv
// ============================================================================
// radix6_input_commutator_if
// Serial sample input and parallel triplet output bundle of the commutator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface radix6_input_commutator_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_img;
    logic          out_valid;
    logic          out_sel;
    logic          out_sof;
    logic [DW-1:0] a_re;
    logic [DW-1:0] a_img;
    logic [DW-1:0] b_re;
    logic [DW-1:0] b_img;
    logic [DW-1:0] c_re;
    logic [DW-1:0] c_img;
    logic          frame_err;

    modport master (
        output in_valid, in_sof, in_re, in_img,
        input  out_valid, out_sel, out_sof,
        input  a_re, a_img, b_re, b_img, c_re, c_img, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_re, in_img,
        output out_valid, out_sel, out_sof,
        output a_re, a_img, b_re, b_img, c_re, c_img, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/frame_bank6.sv
// ============================================================================
// frame_bank6
// Ping-pong pair of 6-slot complex buffers; one write port, 3-slot triplet read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_bank6
    import radix6_pkg::*;
#(
    parameter int DW = 32
) (
    input  wire logic                               clk,
    input  wire logic                               i_wr_en,
    input  wire logic                               i_wr_bank,
    input  wire slot_t                              i_wr_slot,
    input  wire logic [2*DW-1:0]                    i_wr_data,
    input  wire logic                               i_rd_bank,
    input  wire logic                               i_rd_sel,
    output logic      [TRIPLET_N-1:0][2*DW-1:0]     o_rd_data
);

    logic [2*DW-1:0] r_mem [2][FRAME_N];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_slot] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < TRIPLET_N; k++) begin : g_lane
        slot_t w_slot;
        assign w_slot       = i_rd_sel ? ODD_MAP[k] : EVEN_MAP[k];
        assign o_rd_data[k] = r_mem[i_rd_bank][w_slot];
    end

endmodule

`default_nettype wire

// File: rtl/radix6_input_commutator.sv
// ============================================================================
// radix6_input_commutator
// Collects 6-sample frames and re-emits them as even/odd index triplets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module radix6_input_commutator
    import radix6_pkg::*;
#(
    parameter int DW = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    radix6_input_commutator_if.slave  bus
);

    slot_t                          r_wr_cnt;
    logic                           r_wr_bank;
    logic                           r_rd_bank;
    logic                           r_frame_err;
    rd_state_t                      r_state;
    rd_state_t                      w_state_nxt;
    logic                           w_load;
    logic                           w_sel;
    logic                           w_last;
    slot_t                          w_wr_slot;
    logic [TRIPLET_N-1:0][2*DW-1:0] w_rd_data;

    logic                           r_out_valid;
    logic                           r_out_sel;
    logic                           r_out_sof;
    logic [TRIPLET_N-1:0][2*DW-1:0] r_lane;

    // A sof sample always restarts the frame, so it can never complete one
    assign w_last    = bus.in_valid & ~bus.in_sof & (r_wr_cnt == slot_t'(FRAME_N - 1));
    assign w_wr_slot = bus.in_sof ? '0 : r_wr_cnt;

    frame_bank6 #(.DW(DW)) u_bank (
        .clk       (clk),
        .i_wr_en   (bus.in_valid),
        .i_wr_bank (r_wr_bank),
        .i_wr_slot (w_wr_slot),
        .i_wr_data ({bus.in_re, bus.in_img}),
        .i_rd_bank (r_rd_bank),
        .i_rd_sel  (w_sel),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) begin
                r_wr_cnt <= slot_t'(1);
                if (r_wr_cnt != '0) begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_last) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
                r_rd_bank <= r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + slot_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sel       = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (w_last) begin
                    w_state_nxt = RD_EVEN;
                end
            end
            RD_EVEN: begin
                w_load      = 1'b1;
                w_state_nxt = RD_ODD;
            end
            RD_ODD: begin
                w_load      = 1'b1;
                w_sel       = 1'b1;
                w_state_nxt = w_last ? RD_EVEN : RD_IDLE;
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_sof   <= 1'b0;
            r_lane      <= '0;
        end else begin
            r_out_valid <= w_load;
            r_out_sof   <= w_load & ~w_sel;
            if (w_load) begin
                r_out_sel <= w_sel;
                r_lane    <= w_rd_data;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_sof   = r_out_sof;
    assign bus.frame_err = r_frame_err;
    assign bus.a_re      = r_lane[0][2*DW-1:DW];
    assign bus.a_img     = r_lane[0][DW-1:0];
    assign bus.b_re      = r_lane[1][2*DW-1:DW];
    assign bus.b_img     = r_lane[1][DW-1:0];
    assign bus.c_re      = r_lane[2][2*DW-1:DW];
    assign bus.c_img     = r_lane[2][DW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_radix6_input_commutator.sv
// ============================================================================
// tb_radix6_input_commutator
// Scoreboard bench: frame-level reference model feeds expected triplets to a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_radix6_input_commutator;

    typedef struct {
        int unsigned due;
        logic        sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          total;
    int          bad;
    exp_t        sb[$];
    logic [63:0] frm[$];
    bit          exp_err;
    logic [63:0] last_a, last_b, last_c;

    radix6_input_commutator_if #(.DW(32)) bus ();

    radix6_input_commutator #(.DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: collect samples, emit x[even]/x[odd] once six are held
    task automatic model_sample(input bit s, input logic [31:0] re, input logic [31:0] im);
        exp_t e;
        if (s) begin
            if (frm.size() != 0) exp_err = 1'b1;
            frm.delete();
        end
        frm.push_back({re, im});
        if (frm.size() == 6) begin
            for (int p = 0; p < 2; p++) begin
                e.due = cyc + 1 + p;
                e.sel = p[0];
                e.a   = frm[p];
                e.b   = frm[2 + p];
                e.c   = frm[4 + p];
                sb.push_back(e);
            end
            frm.delete();
        end
    endtask

    task automatic send(input bit v, input bit s, input logic [31:0] re, input logic [31:0] im);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_re    = re;
        bus.in_img   = im;
        @(posedge clk);
        #1;
        if (v) model_sample(s, re, im);
    endtask

    task automatic check_zero_outputs();
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_sel",   {63'd0, bus.out_sel},   64'd0);
        chk("rst_out_sof",   {63'd0, bus.out_sof},   64'd0);
        chk("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
        chk("rst_lane_a", {bus.a_re, bus.a_img}, 64'd0);
        chk("rst_lane_b", {bus.b_re, bus.b_img}, 64'd0);
        chk("rst_lane_c", {bus.c_re, bus.c_img}, 64'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_zero_outputs();
        sb.delete();
        frm.delete();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            send(1'b0, 1'b0, 32'd0, 32'd0);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        send(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: compare every presented triplet against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_a = '0;
                last_b = '0;
                last_c = '0;
            end else begin
                chk("frame_err", {63'd0, bus.frame_err}, {63'd0, exp_err});
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("due_cycle", 64'(cyc), 64'(e.due));
                        chk("out_sel", {63'd0, bus.out_sel}, {63'd0, e.sel});
                        chk("out_sof", {63'd0, bus.out_sof}, {63'd0, ~e.sel});
                        chk("lane_a", {bus.a_re, bus.a_img}, e.a);
                        chk("lane_b", {bus.b_re, bus.b_img}, e.b);
                        chk("lane_c", {bus.c_re, bus.c_img}, e.c);
                    end
                    last_a = {bus.a_re, bus.a_img};
                    last_b = {bus.b_re, bus.b_img};
                    last_c = {bus.c_re, bus.c_img};
                end else begin
                    if (sb.size() != 0 && sb[0].due <= cyc) begin
                        chk("missing_valid", 64'd0, 64'd1);
                        void'(sb.pop_front());
                    end
                    chk("idle_hold", {bus.a_re, bus.a_img, bus.b_re[31:0]} == {last_a, last_b[63:32]} &&
                        {bus.b_img, bus.c_re, bus.c_img} == {last_b[31:0], last_c} ? 64'd1 : 64'd0, 64'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, m;
        int          k;
        total        = 0;
        bad          = 0;
        exp_err      = 1'b0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_re    = '0;
        bus.in_img   = '0;
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame, then reset mid-frame and mid-read
        for (int i = 1; i <= 6; i++) send(1'b1, i == 1, 32'(i), -32'(i));
        drain();
        for (int i = 1; i <= 3; i++) send(1'b1, i == 1, 32'(i + 10), 32'(i));
        do_reset();
        for (int i = 1; i <= 6; i++) send(1'b1, i == 1, 32'(i + 20), 32'(i + 7));
        send(1'b0, 1'b0, 32'd0, 32'd0);
        do_reset();
        for (int i = 1; i <= 6; i++) send(1'b1, i == 1, 32'(i), -32'(i));
        drain();

        // Continuous stream of four frames
        for (int i = 0; i < 24; i++) send(1'b1, (i % 6) == 0, 32'(i), 32'(1000 + i));
        drain();

        // Gapped input for one frame
        for (int i = 0; i < 12; i++) send(i[0] == 1'b0, i == 0, 32'(50 + i), 32'(70 + i));
        drain();

        // sof after three samples: partial frame dropped, error sticky
        for (int i = 0; i < 3; i++) send(1'b1, i == 0, 32'(200 + i), 32'(300 + i));
        for (int i = 0; i < 6; i++) send(1'b1, i == 0, 32'(400 + i), 32'(500 + i));
        drain();
        chk("err_sticky", {63'd0, bus.frame_err}, 64'd1);

        // Extreme bit patterns
        for (int i = 0; i < 6; i++) begin
            r = i[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
            m = i[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if (i == 3) r = 32'hFFFF_FFFF;
            send(1'b1, i == 0, r, m);
        end
        drain();

        // Free-running with no sof after reset
        do_reset();
        for (int i = 0; i < 12; i++) send(1'b1, 1'b0, 32'(600 + i), 32'(700 + i));
        drain();
        chk("free_run_err", {63'd0, bus.frame_err}, 64'd0);

        // Random frames with random gaps and occasional mid-frame sof
        for (int f = 0; f < 30; f++) begin
            k = 0;
            while (k < 6) begin
                if ($urandom_range(3, 0) != 0) begin
                    send(1'b1, (k == 0 && $urandom_range(1, 0) == 1) ||
                               (k != 0 && $urandom_range(19, 0) == 0), $urandom, $urandom);
                    k = frm.size();
                    if (k == 0) k = 6;
                end else begin
                    send(1'b0, 1'b0, $urandom, $urandom);
                end
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
